// File: rtl/logic_result_fifo.sv
// logic_result_fifo: show-ahead result FIFO with zero/parity flags and a saturating stall counter
// Ports: clk, rst_n (async active-low); in_valid/in_s/in_ctrl/in_ready producer side;
// out_valid/out_s/out_ctrl/out_zero/out_parity/out_ready consumer side;
// count/full/empty occupancy; stall_cnt counts cycles the producer was refused.
module logic_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_s,
  input  logic [1:0]                 in_ctrl,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_s,
  output logic [1:0]                 out_ctrl,
  output logic                       out_zero,
  output logic                       out_parity,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [CNTW-1:0]            stall_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // entry layout: {ctrl, result, zero, parity}
  logic [WIDTH+3:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_count;
  logic [CNTW-1:0]  r_stall;
  logic             w_push, w_pop;
  assign full      = r_count == CW'(DEPTH);
  assign empty     = r_count == '0;
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign count     = r_count;
  assign stall_cnt = r_stall;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign {out_ctrl, out_s, out_zero, out_parity} = r_mem[r_rd];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_stall <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= {in_ctrl, in_s, ~|in_s, ^in_s};
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      // saturate rather than wrap so a long stall stays visible
      if (in_valid & ~in_ready & ~&r_stall) r_stall <= r_stall + 1'b1;
    end
  end
endmodule
